rsd_write_combiner: RTL and testbench



---
 rtl/rsd_write_combiner.sv | 152 +++++++++++++++
 tb/tb_rsd_write_combiner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsd_write_combiner.sv
// Reed-Solomon decoder write back end: packs decoded symbols MSB-first into cache
// lines, posts one write per line, then writes a completion record to the DSM line.
module rsd_write_combiner #(
  parameter int SYM_WIDTH     = 8,
  parameter int LINE_WIDTH    = 512,
  parameter int NUM_LINE_BUFS = 2,
  parameter int ADDR_WIDTH    = 42,
  parameter int LEN_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] buf_base_addr,
  input  logic [LEN_WIDTH-1:0]  buf_size_lines,
  input  logic [ADDR_WIDTH-1:0] dsm_addr,
  input  logic [SYM_WIDTH-1:0]  sym_data,
  input  logic                  sym_valid,
  input  logic                  sym_last,
  output logic                  sym_ready,
  input  logic                  wr_almfull,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  wr_rsp_valid,
  output logic                  done,
  output logic                  err_overflow,
  output logic [LEN_WIDTH-1:0]  lines_written
);
  localparam int S   = LINE_WIDTH / SYM_WIDTH;
  localparam int SLW = (S > 1) ? $clog2(S) : 1;
  localparam int PW  = (NUM_LINE_BUFS > 1) ? $clog2(NUM_LINE_BUFS) : 1;
  localparam int CW  = $clog2(NUM_LINE_BUFS + 1);
  localparam int LW1 = LEN_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WAIT_RSP, DSM, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  size;
    logic [ADDR_WIDTH-1:0] dsm;
  } cfg_t;

  state_t state, state_nx;
  cfg_t   cfg;

  logic [NUM_LINE_BUFS-1:0][LINE_WIDTH-1:0] lbuf;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        pend_cnt;
  logic [SLW-1:0]       slot;
  logic [LEN_WIDTH-1:0] rsp_cnt;

  logic                  cap_ok, accept, line_done, issue, overflow, start_now, dsm_issue;
  logic [LINE_WIDTH-1:0] sym_top, line_nx, dsm_rec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(NUM_LINE_BUFS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Capacity counts only completed lines; the line being filled becomes the
  // last permitted one when it completes.
  assign cap_ok    = ({1'b0, lines_written} + LW1'(pend_cnt)) < {1'b0, cfg.size};
  assign sym_ready = (state == RUN) && (pend_cnt != CW'(NUM_LINE_BUFS)) && cap_ok;
  assign accept    = sym_valid && sym_ready;
  assign line_done = accept && ((slot == SLW'(S - 1)) || sym_last);
  assign issue     = ((state == RUN) || (state == DRAIN)) && (pend_cnt != '0) && !wr_almfull;
  assign overflow  = (state == RUN) && sym_valid && !cap_ok;
  assign start_now = start && ((state == IDLE) || (state == DONE));

  // Slot 0 starts a fresh line, so unfilled slots are zero without a clear pass.
  assign sym_top = LINE_WIDTH'(sym_data) << (LINE_WIDTH - SYM_WIDTH);
  assign line_nx = ((slot == '0) ? '0 : lbuf[wr_ptr]) | (sym_top >> (SYM_WIDTH * int'(slot)));

  always_comb begin
    dsm_rec                    = '0;
    dsm_rec[0]                 = 1'b1;
    dsm_rec[1]                 = err_overflow;
    dsm_rec[32 +: LEN_WIDTH]   = lines_written;
  end

  always_comb begin
    state_nx  = state;
    dsm_issue = 1'b0;
    case (state)
      IDLE:     if (start) state_nx = RUN;
      RUN:      if ((accept && sym_last) || overflow) state_nx = DRAIN;
      DRAIN:    if (pend_cnt == '0) state_nx = WAIT_RSP;
      WAIT_RSP: if (rsp_cnt == lines_written) state_nx = DSM;
      DSM: begin
        if (!wr_almfull) begin
          dsm_issue = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:     if (start) state_nx = RUN;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cfg           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pend_cnt      <= '0;
      slot          <= '0;
      rsp_cnt       <= '0;
      lines_written <= '0;
      err_overflow  <= 1'b0;
      done          <= 1'b0;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
    end else begin
      state    <= state_nx;
      wr_valid <= 1'b0;
      if (start_now) begin
        cfg           <= '{base: buf_base_addr, size: buf_size_lines, dsm: dsm_addr};
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        pend_cnt      <= '0;
        slot          <= '0;
        rsp_cnt       <= '0;
        lines_written <= '0;
        err_overflow  <= 1'b0;
        done          <= 1'b0;
      end else begin
        if (wr_rsp_valid && (state != IDLE)) rsp_cnt <= rsp_cnt + 1'b1;
        if (accept) begin
          lbuf[wr_ptr] <= line_nx;
          slot         <= line_done ? '0 : slot + 1'b1;
          if (line_done) wr_ptr <= ptr_inc(wr_ptr);
        end
        if (issue) begin
          wr_valid      <= 1'b1;
          wr_addr       <= cfg.base + ADDR_WIDTH'(lines_written);
          wr_data       <= lbuf[rd_ptr];
          rd_ptr        <= ptr_inc(rd_ptr);
          lines_written <= lines_written + 1'b1;
        end
        pend_cnt <= pend_cnt + CW'(line_done) - CW'(issue);
        if (overflow) err_overflow <= 1'b1;
        if (dsm_issue) begin
          wr_valid <= 1'b1;
          wr_addr  <= cfg.dsm;
          wr_data  <= dsm_rec;
          done     <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rsd_write_combiner.sv
// Directed bench: an 8-bit/2-buffer instance and a 32-bit/4-buffer instance,
// with a delayed write responder that can be held off.
module tb_rsd_write_combiner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset0, reset1, start0, start1;
  logic [41:0]  base, dsm;
  logic [31:0]  size;
  logic [31:0]  sym_data;
  logic         sym_valid, sym_last, wr_almfull;
  logic         sym_ready0, wr_valid0, done0, err0, rsp0;
  logic         sym_ready1, wr_valid1, done1, err1, rsp1;
  logic [41:0]  wr_addr0, wr_addr1;
  logic [511:0] wr_data0, wr_data1;
  logic [31:0]  lw0, lw1;

  rsd_write_combiner dut0 (
    .clk(clk), .reset(reset0), .start(start0), .buf_base_addr(base),
    .buf_size_lines(size), .dsm_addr(dsm), .sym_data(sym_data[7:0]),
    .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready0),
    .wr_almfull(wr_almfull), .wr_valid(wr_valid0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .wr_rsp_valid(rsp0), .done(done0),
    .err_overflow(err0), .lines_written(lw0));

  rsd_write_combiner #(.SYM_WIDTH(32), .NUM_LINE_BUFS(4)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .buf_base_addr(base),
    .buf_size_lines(size), .dsm_addr(dsm), .sym_data(sym_data),
    .sym_valid(sym_valid), .sym_last(sym_last), .sym_ready(sym_ready1),
    .wr_almfull(wr_almfull), .wr_valid(wr_valid1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .wr_rsp_valid(rsp1), .done(done1),
    .err_overflow(err1), .lines_written(lw1));

  // Responses arrive ~3 cycles after each write; while held they accumulate.
  logic [3:0] rsp_pipe0;
  int         owed;
  bit         rsp_hold;
  always @(posedge clk) begin
    if (reset0) begin
      rsp_pipe0 <= '0;
      owed      <= 0;
      rsp0      <= 1'b0;
    end else begin
      rsp_pipe0 <= {rsp_pipe0[2:0], wr_valid0};
      if (!rsp_hold && (owed > 0 || rsp_pipe0[2])) begin
        rsp0 <= 1'b1;
        owed <= owed + int'(rsp_pipe0[2]) - 1;
      end else begin
        rsp0 <= 1'b0;
        owed <= owed + int'(rsp_pipe0[2]);
      end
    end
  end

  always @(posedge clk) rsp1 <= reset1 ? 1'b0 : wr_valid1;

  logic [41:0]  a0[$], a1[$];
  logic [511:0] d0[$], d1[$];
  always @(negedge clk) begin
    if (wr_valid0) begin a0.push_back(wr_addr0); d0.push_back(wr_data0); end
    if (wr_valid1) begin a1.push_back(wr_addr1); d1.push_back(wr_data1); end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] line8(input int first, input int n);
    logic [511:0] l = '0;
    for (int k = 0; k < n; k++) l[(63 - k) * 8 +: 8] = 8'(first + k);
    return l;
  endfunction

  function automatic logic [511:0] line32(input int first, input int n);
    logic [511:0] l = '0;
    for (int k = 0; k < n; k++) l[(15 - k) * 32 +: 32] = 32'(first + k);
    return l;
  endfunction

  task automatic send(input bit sel, input int n, input int first, input bit with_last,
                      input bit wait_ready);
    int t;
    for (int i = 0; i < n; i++) begin
      sym_data  = 32'(first + i);
      sym_valid = 1'b1;
      sym_last  = with_last && (i == n - 1);
      t = 0;
      while (wait_ready && !(sel ? sym_ready1 : sym_ready0) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) begin
        checks++;
        errors++;
        $error("FAIL ready_timeout: got sym_ready=0 at symbol %0d expected 1", i);
        break;
      end
      @(negedge clk);
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int t = 0;
    while (!(sel ? done1 : done0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $error("FAIL done_timeout: got done=0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic restart0();
    reset0 = 1'b1;
    repeat (2) @(negedge clk);
    reset0 = 1'b0;
    a0.delete();
    d0.delete();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    sym_valid = 1'b0; sym_last = 1'b0; sym_data = '0; wr_almfull = 1'b0;
    rsp_hold = 1'b0; base = 42'h100; dsm = 42'h200; size = 32'd4;
    repeat (3) @(negedge clk);
    chk("rst_wr_valid", wr_valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_lines", lw0, 0);
    chk("rst_ready", sym_ready0, 0);
    chk("rst_wr_data", wr_data0, 0);
    reset1 = 1'b0;

    // Two full lines, free-flowing.
    restart0();
    send(0, 128, 0, 1, 1);
    wait_done(0);
    chk("t1_nwr", a0.size(), 3);
    chk("t1_addr0", a0[0], 42'h100);
    chk("t1_addr1", a0[1], 42'h101);
    chk("t1_addr_dsm", a0[2], 42'h200);
    chk("t1_l0_top", d0[0][511:504], 8'h00);
    chk("t1_l0_bot", d0[0][7:0], 8'h3F);
    chk("t1_l0", d0[0], line8(0, 64));
    chk("t1_l1", d0[1], line8(64, 64));
    chk("t1_dsm", d0[2], 512'h2_0000_0001);
    chk("t1_done", done0, 1);
    chk("t1_lines", lw0, 2);

    // Back-pressure: a third line must stall with both buffers pending.
    restart0();
    fork
      send(0, 192, 0, 1, 1);
      begin
        repeat (20) @(negedge clk);
        wr_almfull = 1'b1;
        repeat (200) @(negedge clk);
        chk("t2_stall_ready", sym_ready0, 0);
        chk("t2_stall_nwr", a0.size(), 0);
        chk("t2_stall_err", err0, 0);
        wr_almfull = 1'b0;
      end
    join
    wait_done(0);
    chk("t2_nwr", a0.size(), 4);
    chk("t2_addr2", a0[2], 42'h102);
    chk("t2_l0", d0[0], line8(0, 64));
    chk("t2_l1", d0[1], line8(64, 64));
    chk("t2_l2", d0[2], line8(128, 64));
    chk("t2_dsm", d0[3], 512'h3_0000_0001);

    // Partial final line.
    restart0();
    send(0, 70, 0, 1, 1);
    wait_done(0);
    chk("t3_nwr", a0.size(), 3);
    chk("t3_l1", d0[1], line8(64, 6));
    chk("t3_lines", lw0, 2);
    chk("t3_dsm", d0[2], 512'h2_0000_0001);

    // Overflow with a one-line buffer.
    size = 32'd1;
    restart0();
    send(0, 64, 0, 0, 0);
    chk("t4_err_before", err0, 0);
    send(0, 1, 64, 0, 0);
    chk("t4_err_at64", err0, 1);
    send(0, 15, 65, 0, 0);
    wait_done(0);
    chk("t4_nwr", a0.size(), 2);
    chk("t4_l0", d0[0], line8(0, 64));
    chk("t4_dsm", d0[1], 512'h1_0000_0003);
    chk("t4_lines", lw0, 1);

    // Responses withheld.
    size = 32'd4;
    rsp_hold = 1'b1;
    restart0();
    send(0, 192, 0, 1, 1);
    repeat (40) @(negedge clk);
    chk("t5_hold_nwr", a0.size(), 3);
    chk("t5_hold_done", done0, 0);
    chk("t5_hold_lines", lw0, 3);
    rsp_hold = 1'b0;
    wait_done(0);
    chk("t5_nwr", a0.size(), 4);
    chk("t5_addr_dsm", a0[3], 42'h200);
    chk("t5_dsm", d0[3], 512'h3_0000_0001);

    // 32-bit symbols, mid-line reset, restart.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    send(1, 16, 32'h1000_0000, 0, 1);
    repeat (5) @(negedge clk);
    chk("t6_nwr", a1.size(), 1);
    chk("t6_addr", a1[0], 42'h100);
    chk("t6_first_sym", d1[0][511:480], 32'h1000_0000);
    chk("t6_l0", d1[0], line32(32'h1000_0000, 16));
    chk("t6_lines", lw1, 1);
    send(1, 5, 32'h2000_0000, 0, 1);
    reset1 = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", wr_valid1, 0);
    chk("t6_rst_ready", sym_ready1, 0);
    chk("t6_rst_done", done1, 0);
    chk("t6_rst_err", err1, 0);
    chk("t6_rst_lines", lw1, 0);
    reset1 = 1'b0;
    a1.delete();
    d1.delete();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    send(1, 16, 32'h3000_0000, 1, 1);
    wait_done(1);
    chk("t6r_nwr", a1.size(), 2);
    chk("t6r_l0", d1[0], line32(32'h3000_0000, 16));
    chk("t6r_dsm", d1[1], 512'h1_0000_0001);
    chk("t6r_lines", lw1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
